// File: rtl/ram_fifo.sv
// ---------------------------------------------------------------------------
// ram_fifo : first-word-fall-through FIFO built on a 1R1W block RAM with a
// registered read port, followed by a 2-entry in-order skid buffer that hides
// the one-cycle RAM read latency.
//
// Parameters
//   WIDTH     data width in bits
//   LG_DEPTH  log2 of the number of RAM entries (DEPTH = 1 << LG_DEPTH)
//
// Ports
//   clk        sole clock, all state updates on its rising edge
//   reset_n    asynchronous active-low reset
//   in_valid   producer offers in_data this cycle
//   in_data    write data
//   in_ready   FIFO accepts a word this cycle (RAM occupancy < DEPTH)
//   out_valid  out_data holds the oldest unpopped word
//   out_data   oldest word (first-word-fall-through from the skid head)
//   out_ready  consumer takes out_data this cycle
//   count      total occupancy (RAM + reads in flight + skid entries);
//              only present when RAM_FIFO_COUNT_EN is defined
//
// Optional feature macro: RAM_FIFO_COUNT_EN
//
// Total capacity is DEPTH + 2 words: DEPTH in the RAM plus two in the skid.
// ---------------------------------------------------------------------------
module ram_fifo #(
  parameter int WIDTH    = 32,
  parameter int LG_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef RAM_FIFO_COUNT_EN
  ,
  output logic [LG_DEPTH+1:0] count
`endif
);

  localparam int DEPTH = 1 << LG_DEPTH;

  // Pointers, RAM occupancy and read pipeline state
  logic [LG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LG_DEPTH:0]   occ_q, occ_d;
  logic                inflight_q, inflight_d;

  // Skid buffer: entry 0 is the head; entry 1 is only valid if entry 0 is.
  logic [1:0]          skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0]    skid_data_q [2];
  logic [WIDTH-1:0]    skid_data_d [2];

  // Storage and registered read port
  logic [WIDTH-1:0]    mem [DEPTH];
  logic [WIDTH-1:0]    rd_data_q;

  logic                push;
  logic                pop;
  logic                issue;
  logic [1:0]          skid_cnt;
  logic [2:0]          pipe_load;

  // occ_q never exceeds DEPTH, so "occupancy < DEPTH" is simply "MSB clear".
  // This keeps in_ready purely state-derived with no path from out_ready.
  assign in_ready  = ~occ_q[LG_DEPTH];
  assign out_valid = skid_vld_q[0];
  assign out_data  = skid_data_q[0];

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Words already committed downstream of the RAM, net of this cycle's pop.
  // A pop implies skid_cnt >= 1, so the subtraction cannot underflow.
  assign skid_cnt  = 2'(skid_vld_q[0]) + 2'(skid_vld_q[1]);
  assign pipe_load = {1'b0, skid_cnt} + {2'b00, inflight_q} - {2'b00, pop};

  // A read is only launched if the skid is guaranteed room for its data when
  // it lands next cycle; this is what bounds the skid at two entries.
  assign issue = (occ_q != '0) && (pipe_load < 3'd2);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q + LG_DEPTH'(push);
    rd_ptr_d   = rd_ptr_q + LG_DEPTH'(issue);
    occ_d      = occ_q + (LG_DEPTH+1)'(push) - (LG_DEPTH+1)'(issue);
    inflight_d = issue;
  end

  // Skid update: apply the pop first (shift entry 1 into the head), then
  // append the landing read data into the first free slot of the result.
  always_comb begin
    skid_vld_d     = skid_vld_q;
    skid_data_d[0] = skid_data_q[0];
    skid_data_d[1] = skid_data_q[1];

    if (pop) begin
      skid_vld_d     = {1'b0, skid_vld_q[1]};
      skid_data_d[0] = skid_data_q[1];
    end

    if (inflight_q) begin
      if (!skid_vld_d[0]) begin
        skid_vld_d[0]  = 1'b1;
        skid_data_d[0] = rd_data_q;
      end else begin
        skid_vld_d[1]  = 1'b1;
        skid_data_d[1] = rd_data_q;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Control state registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;   // drops any read that was in flight
      skid_vld_q <= 2'b00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  // -------------------------------------------------------------------------
  // RAM: not reset. The nonblocking write means a same-address read in the
  // same cycle returns the old contents.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_data;
    end
    if (issue) begin
      rd_data_q <= mem[rd_ptr_q];
    end
  end

  // Skid data payload carries no reset; its valid bits qualify it.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_skid
      always_ff @(posedge clk) begin
        skid_data_q[gi] <= skid_data_d[gi];
      end
    end
  endgenerate

`ifdef RAM_FIFO_COUNT_EN
  // Every word moves RAM -> in flight -> skid without changing the total,
  // so the sum only changes on a push or a pop.
  logic [LG_DEPTH+1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + (LG_DEPTH+2)'(push) - (LG_DEPTH+2)'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
`endif

endmodule

// File: doc/ram_fifo.md
RAM_FIFO -- requirements
Module: ram_fifo

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits.
REQ-002 Parameter LG_DEPTH, default 4: log2 of RAM entries; DEPTH = 1<<LG_DEPTH.
REQ-003 clk  input  1  sole clock; all state on posedge clk.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  producer has a word on in_data.
REQ-006 in_data  input  WIDTH  write data.
REQ-007 in_ready  output  1  FIFO can accept a word this cycle.
REQ-008 out_valid  output  1  out_data holds the oldest unpopped word.
REQ-009 out_data  output  WIDTH  oldest word, first-word-fall-through.
REQ-010 out_ready  input  1  consumer takes out_data this cycle.
REQ-011 count  output  LG_DEPTH+2  total occupancy; present only under RAM_FIFO_COUNT_EN.

Function
REQ-012 Storage SHALL be a DEPTH x WIDTH 1R1W RAM with registered read: address presented in cycle c, data valid in cycle c+1; same-address write and read in one cycle returns old data.
REQ-013 Push occurs when in_valid & in_ready; the word is written at wr_ptr that cycle and wr_ptr increments mod DEPTH.
REQ-014 in_ready SHALL be 1 iff RAM occupancy < DEPTH; it is registered/state-derived, with no combinational path from out_ready.
REQ-015 Read engine: issues a read at rd_ptr in cycle c iff RAM occupancy > 0 and (skid entries + reads in flight − pop in c) < 2; rd_ptr increments mod DEPTH on issue.
REQ-016 Read data SHALL be captured at the end of cycle c+1 into a 2-entry in-order skid buffer; out_data/out_valid are driven from the skid head register.
REQ-017 Pop occurs when out_valid & out_ready; the head advances; a pop and a skid capture in the same cycle SHALL both take effect.
REQ-018 Total capacity SHALL be DEPTH+2 words (RAM + skid); words SHALL emerge in push order, none dropped or duplicated.
REQ-019 Latency: on an empty FIFO, a push accepted in cycle p SHALL give out_valid=1 first in cycle p+3.
REQ-020 Throughput: with in_valid=1 and out_ready=1 held, one word per cycle in steady state.
REQ-021 A push with in_ready=0 SHALL be ignored; a pop with out_valid=0 SHALL be ignored.
REQ-022 Simultaneous push and read issue in one cycle SHALL both proceed; occupancy is net of both.
REQ-023 Pointers wrap from DEPTH-1 to 0 with no gap or bubble.
REQ-024 out_data SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-025 reset_n=0 SHALL asynchronously clear wr_ptr, rd_ptr, RAM occupancy, in-flight flag and skid valids.
REQ-026 Reset values during and immediately after reset: out_valid=0, in_ready=1, count=0; out_data value is don't-care.
REQ-027 RAM contents are not reset; a read in flight when reset asserts SHALL be discarded.
REQ-028 First push is accepted in the first cycle with reset_n=1.

Configuration
REQ-029 Macro RAM_FIFO_COUNT_EN: when defined, port count exists and equals RAM occupancy + reads in flight + valid skid entries, updated every cycle, range 0..DEPTH+2.
REQ-030 Without RAM_FIFO_COUNT_EN, port count and its counter logic SHALL be absent; all other behaviour is unchanged.

Verification (WIDTH=8, LG_DEPTH=2: DEPTH=4, capacity 6)
REQ-031 Reset, then push 0xA5 in cycle p with out_ready=0 -> out_valid=1 in cycle p+3, out_data=0xA5, count=1.
REQ-032 out_ready=0; push 0x01..0x08 back to back -> 0x01..0x06 accepted, in_ready=0 once the RAM holds 4, count=6; draining yields 0x01..0x06 in order.
REQ-033 in_valid=1 and out_ready=1 held for 20 pushes 0x00..0x13 -> outputs 0x00..0x13 in order; one per cycle after the initial fill; pointers wrap 5 times.
REQ-034 Random in_valid and out_ready, 1000 words -> scoreboard exact in-order match; out_data stable whenever stalled.
REQ-035 Assert reset_n=0 for one cycle with 3 words stored and one read in flight -> out_valid=0, count=0, in_ready=1 immediately; next push 0x5A is the first output.
REQ-036 Compile without RAM_FIFO_COUNT_EN and rerun REQ-033 -> identical data behaviour, no count port.
